// File: rtl/imem_loader.sv
// Instruction memory with a streaming program loader and a one-cycle fetch port.
// LOAD fills the memory word by word; RUN serves fetches checked against the loaded count.
module imem_loader #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  input  logic                     reload,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_inst,
  output logic                     fetch_err,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            armed;
  logic [AW-1:0]   wptr;
  logic [31:0]     mem [DEPTH];
  logic            accept;
  logic            last_slot;
  logic            addr_ok;
  logic [AW-1:0]   rd_idx;

  // armed holds ld_ready low until the first edge after reset is released
  assign ld_ready  = (state == LOAD) && armed;
  assign stall     = (state != RUN);
  assign last_slot = (wptr == AW'(DEPTH - 1));
  assign accept    = ld_valid && ld_ready && !reload;

  assign rd_idx  = fetch_addr[AW+1:2];
  assign addr_ok = (state == RUN) && (fetch_addr[1:0] == 2'b00) &&
                   (32'(fetch_addr[31:2]) < 32'(ld_count));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && (ld_last || last_slot)) state_nxt = RUN;
      RUN:  if (reload)                            state_nxt = LOAD;
      default:                                     state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed    <= 1'b0;
      wptr     <= '0;
      ld_count <= '0;
    end else begin
      armed <= 1'b1;
      if (reload) begin
        wptr     <= '0;
        ld_count <= '0;
      end else if (accept) begin
        wptr     <= wptr + {{(AW-1){1'b0}}, 1'b1};
        ld_count <= ld_count + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Contents are never cleared; ld_count alone decides which words are valid
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= ld_data;
    end
  end

  // Response stage: every request yields exactly one valid cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_inst  <= NOP;
    end else begin
      fetch_valid <= fetch_req;
      if (fetch_req && addr_ok) begin
        fetch_inst <= mem[rd_idx];
        fetch_err  <= 1'b0;
      end else begin
        fetch_inst <= NOP;
        fetch_err  <= fetch_req;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, fetch, error cases, reload, full-memory stream and reset abort.
module tb_imem_loader;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        reload = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_err;
  logic        stall;
  logic [4:0]  ld_count;

  int n_cmp = 0;
  int n_err = 0;

  imem_loader #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_err(fetch_err),
    .stall(stall), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] inst, input logic err);
    chk({tag, "_vld"}, 32'(fetch_valid), 32'd1);
    chk({tag, "_inst"}, fetch_inst, inst);
    chk({tag, "_err"}, 32'(fetch_err), 32'(err));
  endtask

  initial begin
    // reset state
    repeat (2) step();
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_fvld", 32'(fetch_valid), 32'd0);
    chk("rst_ferr", 32'(fetch_err), 32'd0);
    chk("rst_finst", fetch_inst, NOP);

    rst = 1'b1;
    step();
    chk("arm_ready", 32'(ld_ready), 32'd1);
    chk("arm_stall", 32'(stall), 32'd1);

    // three-word program
    ld_valid = 1'b1; ld_data = 32'h2008_0005; step();
    ld_data = 32'h2129_0001; step();
    ld_data = 32'hAC09_0000; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld3_count", 32'(ld_count), 32'd3);
    chk("ld3_ready", 32'(ld_ready), 32'd0);
    chk("ld3_stall", 32'(stall), 32'd0);

    // back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 32'h0; step();
    chk_resp("f0", 32'h2008_0005, 1'b0);
    fetch_addr = 32'h4; step();
    chk_resp("f4", 32'h2129_0001, 1'b0);
    fetch_addr = 32'h8; step();
    chk_resp("f8", 32'hAC09_0000, 1'b0);
    fetch_req = 1'b0; step();
    chk("idle_fvld", 32'(fetch_valid), 32'd0);

    // error cases
    fetch_req = 1'b1; fetch_addr = 32'h6; step();
    chk_resp("mis6", NOP, 1'b1);
    fetch_addr = 32'hC; step();
    chk_resp("oorC", NOP, 1'b1);
    fetch_addr = 32'h4000_0000; step();
    chk_resp("oorhi", NOP, 1'b1);

    // reload with a concurrent fetch answers from old contents
    reload = 1'b1; fetch_addr = 32'h4; step();
    reload = 1'b0;
    chk_resp("rl_f4", 32'h2129_0001, 1'b0);
    chk("rl_stall", 32'(stall), 32'd1);
    chk("rl_ready", 32'(ld_ready), 32'd1);
    chk("rl_count", 32'(ld_count), 32'd0);
    step();
    chk_resp("load_f4", NOP, 1'b1);
    fetch_req = 1'b0;

    // reload in LOAD discards the offered word
    ld_valid = 1'b1; ld_data = 32'hBAD0_BAD0; reload = 1'b1; step();
    reload = 1'b0; ld_valid = 1'b0;
    chk("rlld_count", 32'(ld_count), 32'd0);
    chk("rlld_ready", 32'(ld_ready), 32'd1);

    // stream a full memory without ld_last
    ld_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ld_data = 32'hA500_0000 + 32'(i);
      step();
      if (i == 7) chk("full_mid", 32'(ld_count), 32'd8);
    end
    chk("full_count", 32'(ld_count), 32'(DEPTH));
    chk("full_stall", 32'(stall), 32'd0);
    chk("full_ready", 32'(ld_ready), 32'd0);
    ld_data = 32'hFFFF_FFFF; step();
    ld_valid = 1'b0;
    chk("full_extra", 32'(ld_count), 32'(DEPTH));
    fetch_req = 1'b1; fetch_addr = 32'((DEPTH - 1) * 4); step();
    chk_resp("full_last", 32'hA500_000F, 1'b0);
    fetch_addr = 32'h0; step();
    chk_resp("full_first", 32'hA500_0000, 1'b0);
    fetch_req = 1'b0;

    // reset mid-load with a pending error response
    reload = 1'b1; step();
    reload = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h1234_0001; step();
    ld_data = 32'h1234_0002; fetch_req = 1'b1; fetch_addr = 32'h0; step();
    ld_valid = 1'b0; fetch_req = 1'b0;
    chk("mid_count", 32'(ld_count), 32'd2);
    chk_resp("mid_resp", NOP, 1'b1);
    rst = 1'b0;
    #1;
    chk("ar_fvld", 32'(fetch_valid), 32'd0);
    chk("ar_ferr", 32'(fetch_err), 32'd0);
    chk("ar_count", 32'(ld_count), 32'd0);
    chk("ar_ready", 32'(ld_ready), 32'd0);
    chk("ar_stall", 32'(stall), 32'd1);
    repeat (2) step();
    rst = 1'b1;
    step();
    ld_valid = 1'b1; ld_data = 32'h1111_1111; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("post_count", 32'(ld_count), 32'd1);
    chk("post_stall", 32'(stall), 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'h0; step();
    chk_resp("post_f0", 32'h1111_1111, 1'b0);
    fetch_addr = 32'h4; step();
    chk_resp("post_f4", NOP, 1'b1);
    fetch_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
